// File: rtl/gpu_pkg.sv
// Register map shared by the GPU command front end, the GPU core and firmware headers.
package gpu_pkg;

    typedef enum logic [1:0] {
        RegCmd    = 2'd0,
        RegStatus = 2'd1,
        RegCtrl   = 2'd2,
        RegRsvd   = 2'd3
    } reg_off_e;

    localparam logic [3:0] REG_CMD_OFS    = 4'h0;
    localparam logic [3:0] REG_STATUS_OFS = 4'h4;
    localparam logic [3:0] REG_CTRL_OFS   = 4'h8;

    localparam int unsigned STAT_EMPTY_BIT = 16;
    localparam int unsigned STAT_FULL_BIT  = 17;
    localparam int unsigned STAT_OVF_BIT   = 18;
    localparam int unsigned STAT_BUSY_BIT  = 19;

    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;

    localparam logic [3:0] SEL_ALL = 4'hF;

    function automatic logic [31:0] pack_status(input logic [15:0] level, input logic empty,
                                                input logic full, input logic ovf,
                                                input logic busy);
        logic [31:0] s;
        s                 = {16'h0000, level};
        s[STAT_EMPTY_BIT] = empty;
        s[STAT_FULL_BIT]  = full;
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_BUSY_BIT]  = busy;
        return s;
    endfunction

endpackage

// File: rtl/gpu_cmd_sync_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush, level/full/empty and a registered head word.
module gpu_cmd_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head,
    output logic [LW-1:0]    o_level,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_level;
    logic             r_valid;
    logic [WIDTH-1:0] r_head;

    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_rd_ptr_d;
    logic [AW-1:0]    w_wr_ptr_d;
    logic [LW-1:0]    w_level_d;
    logic             w_valid_d;
    logic [WIDTH-1:0] w_head_d;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_valid = r_valid;
    assign o_head  = r_head;
    assign o_level = r_level;

    always_comb begin
        w_do_pop   = i_pop && !o_empty && !i_flush;
        w_do_push  = i_push && (!o_full || w_do_pop) && !i_flush;
        w_rd_ptr_d = r_rd_ptr;
        w_wr_ptr_d = r_wr_ptr;
        w_level_d  = r_level;
        w_head_d   = r_head;
        if (i_flush) begin
            w_rd_ptr_d = '0;
            w_wr_ptr_d = '0;
            w_level_d  = '0;
        end else begin
            if (w_do_pop) begin
                w_rd_ptr_d = r_rd_ptr + 1'b1;
            end
            if (w_do_push) begin
                w_wr_ptr_d = r_wr_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   w_level_d = r_level + 1'b1;
                2'b01:   w_level_d = r_level - 1'b1;
                default: w_level_d = r_level;
            endcase
            // New head comes from storage if entries remain, else straight from the push.
            if (w_do_pop && (r_level > LW'(1))) begin
                w_head_d = r_mem[w_rd_ptr_d];
            end else if (w_do_push && (o_empty || w_do_pop)) begin
                w_head_d = i_wdata;
            end
        end
        w_valid_d = (w_level_d != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_d;
            r_wr_ptr <= w_wr_ptr_d;
            r_level  <= w_level_d;
            r_valid  <= w_valid_d;
            r_head   <= w_head_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/gpu_cmd_frontend.sv
// Wishbone slave that queues 32-bit command words for the GPU core and reports FIFO status.
module gpu_cmd_frontend
    import gpu_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int unsigned DEPTH     = 16,
    localparam int unsigned LW       = $clog2(DEPTH) + 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cmd_valid_o,
    output logic [31:0] cmd_data_o,
    input  logic        cmd_ready_i,
    input  logic        gpu_busy_i
);

    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_we;
    reg_off_e    r_off;
    logic        r_sel_all;
    logic [31:0] r_wdat;
    logic        r_ovf;

    logic          w_hit;
    logic          w_req;
    reg_off_e      w_off;
    logic [31:0]   w_rd_data;
    logic          w_wr_act;
    logic          w_push_req;
    logic          w_flush;
    logic          w_clr_ovf;
    logic          w_pop;
    logic          w_drop;
    logic          w_ovf_d;
    logic          w_fifo_valid;
    logic [31:0]   w_fifo_head;
    logic [LW-1:0] w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_unused_adr;

    assign w_unused_adr = ^wbs_adr_i[1:0];
    assign w_hit        = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign w_req        = wbs_stb_i && wbs_cyc_i && w_hit && !r_ack;
    assign w_off        = reg_off_e'(wbs_adr_i[3:2]);

    always_comb begin
        w_rd_data = '0;
        if (w_off == RegStatus) begin
            w_rd_data = pack_status(16'(w_level), w_empty, w_full, r_ovf, gpu_busy_i);
        end
    end

    // Write side effects are applied in the ack cycle from the captured request.
    assign w_wr_act   = r_ack && r_we;
    assign w_push_req = w_wr_act && (r_off == RegCmd) && r_sel_all;
    assign w_flush    = w_wr_act && (r_off == RegCtrl) && r_wdat[CTRL_FLUSH_BIT];
    assign w_clr_ovf  = w_wr_act && (r_off == RegCtrl) && r_wdat[CTRL_CLR_OVF_BIT];
    assign w_pop      = w_fifo_valid && cmd_ready_i;
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_comb begin
        w_ovf_d = r_ovf;
        if (w_drop) begin
            w_ovf_d = 1'b1;
        end else if (w_clr_ovf) begin
            w_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_we      <= 1'b0;
            r_off     <= RegCmd;
            r_sel_all <= 1'b0;
            r_wdat    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wbs_we_i) ? w_rd_data : '0;
            if (w_req) begin
                r_we      <= wbs_we_i;
                r_off     <= w_off;
                r_sel_all <= (wbs_sel_i == SEL_ALL);
                r_wdat    <= wbs_dat_i;
            end
            r_ovf <= w_ovf_d;
        end
    end

    gpu_cmd_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_push  (w_push_req),
        .i_pop   (w_pop && !w_flush),
        .i_flush (w_flush),
        .i_wdata (r_wdat),
        .o_valid (w_fifo_valid),
        .o_head  (w_fifo_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign cmd_valid_o = w_fifo_valid;
    assign cmd_data_o  = w_fifo_head;

endmodule

// File: tb/tb_gpu_cmd_frontend.sv
// Scoreboard bench for gpu_cmd_frontend: directed plan steps followed by randomized traffic.
module tb_gpu_cmd_frontend;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready = 1'b0;
    logic        gpu_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpu_cmd_frontend #(
        .ADDR_BASE (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .cmd_valid_o (cmd_valid),
        .cmd_data_o  (cmd_data),
        .cmd_ready_i (cmd_ready),
        .gpu_busy_i  (gpu_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the words the GPU should see, in order, plus the sticky overflow flag.
    logic [31:0] model_q[$];
    bit          model_ovf = 1'b0;
    bit          mon_en    = 1'b0;

    typedef struct packed {
        logic        we;
        logic [1:0]  off;
        logic        sel_all;
        logic [31:0] wdat;
        logic [31:0] exp_rd;
    } txn_t;
    txn_t pend[$];

    function automatic logic [31:0] model_status(input logic busy);
        logic [31:0] s;
        s     = 32'(model_q.size());
        s[16] = (model_q.size() == 0);
        s[17] = (model_q.size() == DEPTH);
        s[18] = model_ovf;
        s[19] = busy;
        return s;
    endfunction

    always @(negedge clk) begin : monitor
        txn_t t;
        bit   do_push;
        bit   do_flush;
        bit   do_clr;
        bit   pop_now;
        if (mon_en) begin
            check("cmd_valid", 32'(cmd_valid), 32'(model_q.size() != 0));
            if (model_q.size() != 0) check("cmd_head", cmd_data, model_q[0]);
            if (!ack) check("dat_idle_zero", rdat, 32'h0);
            if (rst) begin
                model_q.delete();
                model_ovf = 1'b0;
                pend.delete();
            end else begin
                do_push  = 1'b0;
                do_flush = 1'b0;
                do_clr   = 1'b0;
                pop_now  = (model_q.size() != 0) && cmd_ready;
                if (stb && cyc && !ack && (adr[31:4] == BASE[31:4])) begin
                    t.we      = we;
                    t.off     = adr[3:2];
                    t.sel_all = (sel == 4'hF);
                    t.wdat    = wdat;
                    t.exp_rd  = (!we && adr[3:2] == 2'd1) ? model_status(gpu_busy) : 32'h0;
                    pend.push_back(t);
                end else if (ack) begin
                    check("ack_has_txn", 32'(pend.size() != 0), 32'h1);
                    if (pend.size() != 0) begin
                        t = pend.pop_front();
                        check("ack_rdata", rdat, t.exp_rd);
                        do_push  = t.we && (t.off == 2'd0) && t.sel_all;
                        do_flush = t.we && (t.off == 2'd2) && t.wdat[0];
                        do_clr   = t.we && (t.off == 2'd2) && t.wdat[1];
                    end
                end
                if (do_flush) begin
                    model_q.delete();
                end else begin
                    if (pop_now) void'(model_q.pop_front());
                    if (do_push) begin
                        if (model_q.size() < DEPTH) model_q.push_back(t.wdat);
                        else model_ovf = 1'b1;
                    end
                end
                if (do_clr && !(do_push && model_ovf)) model_ovf = 1'b0;
            end
        end
    end

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit pop_in_ack, input bit expect_ack,
                             output logic [31:0] rd);
        int lat;
        lat = -1;
        @(posedge clk);
        #1;
        stb  = 1'b1;
        cyc  = 1'b1;
        we   = w;
        adr  = a;
        wdat = d;
        sel  = s;
        if (pop_in_ack) begin
            fork
                begin
                    @(posedge clk);
                    #1 cmd_ready = 1'b1;
                    @(posedge clk);
                    #1 cmd_ready = 1'b0;
                end
            join_none
        end
        for (int n = 0; n < 8 && lat < 0; n++) begin
            @(negedge clk);
            if (ack) lat = n;
        end
        rd = rdat;
        @(posedge clk);
        #1;
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        if (expect_ack) check("ack_latency", 32'(lat), 32'd1);
        else check("no_ack_outside", 32'(lat), 32'hFFFF_FFFF);
    endtask

    task automatic wr(input logic [3:0] ofs, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(1'b1, BASE + 32'(ofs), d, 4'hF, 1'b0, 1'b1, dummy);
    endtask

    task automatic rd_reg(input logic [3:0] ofs, output logic [31:0] d);
        wb_access(1'b0, BASE + 32'(ofs), 32'h0, 4'hF, 1'b0, 1'b1, d);
    endtask

    int rnd_en  = 0;
    int rdy_pct = 50;

    always @(posedge clk) begin
        #1;
        if (rnd_en != 0) begin
            cmd_ready = ($urandom_range(0, 99) < rdy_pct);
            gpu_busy  = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          kind;
        int          done;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_valid", 32'(cmd_valid), 32'h0);
        check("rst_data", cmd_data, 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;

        rd_reg(4'h4, r);
        check("status_after_reset", r, 32'h0001_0000);

        wr(4'h0, 32'hA5A5_0001);
        @(negedge clk);
        check("valid_two_cycles", 32'(cmd_valid), 32'h1);
        wr(4'h0, 32'hA5A5_0002);
        wr(4'h0, 32'hA5A5_0003);
        rd_reg(4'h4, r);
        check("status_level3", r, 32'h0000_0003);
        check("head_first_word", cmd_data, 32'hA5A5_0001);

        for (int i = 4; i <= DEPTH; i++) wr(4'h0, 32'hA5A5_0000 + 32'(i));
        wr(4'h0, 32'hDEAD_BEEF);
        rd_reg(4'h4, r);
        check("status_full_ovf", r, 32'h0006_0010);
        wr(4'h8, 32'h2);
        rd_reg(4'h4, r);
        check("status_ovf_cleared", r, 32'h0002_0010);

        wb_access(1'b1, BASE, 32'h1234_5678, 4'hF, 1'b1, 1'b1, r);
        rd_reg(4'h4, r);
        check("full_push_with_pop", r, 32'h0002_0010);

        @(posedge clk);
        #1 cmd_ready = 1'b1;
        done = 0;
        for (int n = 0; n < 100 && done == 0; n++) begin
            @(negedge clk);
            if (model_q.size() == 0) done = 1;
        end
        check("drain_done", 32'(done), 32'h1);
        @(posedge clk);
        #1 cmd_ready = 1'b0;

        for (int i = 0; i < 5; i++) wr(4'h0, 32'hC0DE_0000 + 32'(i));
        wb_access(1'b1, BASE, 32'hBAD0_0000, 4'h3, 1'b0, 1'b1, r);
        rd_reg(4'h4, r);
        check("partial_sel_ignored", r, 32'h0000_0005);
        wr(4'h8, 32'h1);
        @(negedge clk);
        check("flush_valid_low", 32'(cmd_valid), 32'h0);
        rd_reg(4'h4, r);
        check("status_after_flush", r, 32'h0001_0000);

        wb_access(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, r);
        rd_reg(4'hC, r);
        check("reserved_reads_zero", r, 32'h0);
        wr(4'hC, 32'hFFFF_FFFF);
        rd_reg(4'h8, r);
        check("ctrl_reads_zero", r, 32'h0);

        for (int i = 0; i < 3; i++) wr(4'h0, 32'h7700_0000 + 32'(i));
        @(posedge clk);
        #1;
        rst  = 1'b1;
        stb  = 1'b1;
        cyc  = 1'b1;
        we   = 1'b1;
        adr  = BASE;
        wdat = 32'h5555_AAAA;
        sel  = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_discards", 32'(cmd_valid), 32'h0);
        rd_reg(4'h4, r);
        check("status_after_midreset", r, 32'h0001_0000);

        for (int phase = 0; phase < 3; phase++) begin
            rdy_pct = (phase == 0) ? 60 : (phase == 1) ? 15 : 90;
            rnd_en  = 1;
            for (int i = 0; i < 150; i++) begin
                kind = $urandom_range(0, 99);
                if (kind < 70) begin
                    wb_access(1'b1, BASE, $urandom, ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF,
                              1'b0, 1'b1, r);
                end else if (kind < 85) begin
                    rd_reg(4'h4, r);
                end else if (kind < 95) begin
                    wr(4'h8, ($urandom_range(0, 5) == 0) ? 32'h1 : 32'h2);
                end else begin
                    wb_access(1'($urandom_range(0, 1)), BASE + 32'hC, $urandom, 4'hF, 1'b0, 1'b1, r);
                end
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            end
            rnd_en = 0;
        end

        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        gpu_busy  = 1'b0;
        repeat (4) @(negedge clk);
        check("no_pending_acks", 32'(pend.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
